keypad_scan: RTL and testbench

//  Scans a 4x4 active-low matrix keypad, debounces it and drives the key[3:0] code consumed by the

---
 rtl/keypad_scan_pkg.sv | 61 ++++++
 rtl/keypad_scan_debounce.sv | 141 ++++++++++++++
 rtl/keypad_scan.sv | 135 +++++++++++++
 tb/tb_keypad_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : keypad_scan_pkg
//  Brief   : Key codes, debounce state encoding and 4x4 keymap lookup shared
//            by the keypad scanner and its debounce FSM.
//  Revision: 1.0 - initial release
// ============================================================================
package keypad_scan_pkg;

   localparam logic [3:0] c_key_0     = 4'h0;
   localparam logic [3:0] c_key_1     = 4'h1;
   localparam logic [3:0] c_key_2     = 4'h2;
   localparam logic [3:0] c_key_3     = 4'h3;
   localparam logic [3:0] c_key_4     = 4'h4;
   localparam logic [3:0] c_key_5     = 4'h5;
   localparam logic [3:0] c_key_6     = 4'h6;
   localparam logic [3:0] c_key_7     = 4'h7;
   localparam logic [3:0] c_key_8     = 4'h8;
   localparam logic [3:0] c_key_9     = 4'h9;
   localparam logic [3:0] c_key_a     = 4'hA;
   localparam logic [3:0] c_key_b     = 4'hB;
   localparam logic [3:0] c_key_c     = 4'hC;
   localparam logic [3:0] c_key_enter = 4'hD;
   localparam logic [3:0] c_key_esc   = 4'hE;
   localparam logic [3:0] c_key_none  = 4'hF;

   // Debounce FSM states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESS_CHK = 2'd1,
      ST_HELD      = 2'd2,
      ST_REL_CHK   = 2'd3
   } deb_state_t;

   // Keymap indexed by row*4+col; r3c3 is not populated on the keypad
   function automatic logic [3:0] f_keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = c_key_none;
      case ({row, col})
         4'h0: code = c_key_1;
         4'h1: code = c_key_2;
         4'h2: code = c_key_3;
         4'h3: code = c_key_a;
         4'h4: code = c_key_4;
         4'h5: code = c_key_5;
         4'h6: code = c_key_6;
         4'h7: code = c_key_b;
         4'h8: code = c_key_7;
         4'h9: code = c_key_8;
         4'hA: code = c_key_9;
         4'hB: code = c_key_c;
         4'hC: code = c_key_esc;
         4'hD: code = c_key_0;
         4'hE: code = c_key_enter;
         default: code = c_key_none;
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : keypad_debounce
//  Brief   : Press/release debounce FSM evaluated once per full keypad scan.
//            Optional auto-repeat when KEYPAD_REPEAT_EN is defined.
//  Revision: 1.0 - initial release
// ============================================================================
module keypad_debounce
   import keypad_scan_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 32,
   parameter int REPEAT_PERIOD  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_scan_end,
   input  logic [3:0] i_raw,
   output logic [3:0] o_key,
   output logic       o_key_stb
);

   localparam logic [3:0] c_DEB = 4'(DEBOUNCE_SCANS);

   // Elaboration-time parameter sanity checks
   if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
      $error("keypad_debounce: DEBOUNCE_SCANS must be 2..15");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("keypad_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   deb_state_t r_state;
   logic [3:0] r_cand;
   logic [3:0] r_cnt;
   logic [3:0] r_key;
   logic       r_key_stb;
   logic [3:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + 4'd1;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [15:0] c_RD  = 16'(REPEAT_DELAY);
   localparam logic [15:0] c_RDP = 16'(REPEAT_DELAY + REPEAT_PERIOD);
   logic [15:0] r_rep;
   logic [15:0] w_rep_inc;
   assign w_rep_inc = r_rep + 16'd1;
`endif

   // Debounce FSM: state, candidate, match counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cand    <= c_key_none;
         r_cnt     <= 4'd0;
         r_key     <= c_key_none;
         r_key_stb <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         r_rep     <= 16'd0;
`endif
      end else begin
         r_key_stb <= 1'b0;
         if (i_scan_end) begin
            case (r_state)
               ST_IDLE: begin
                  if (i_raw != c_key_none) begin
                     r_state <= ST_PRESS_CHK;
                     r_cand  <= i_raw;
                     r_cnt   <= 4'd1;
                  end
               end
               ST_PRESS_CHK: begin
                  if (i_raw == r_cand) begin
                     if (w_cnt_inc == c_DEB) begin
                        r_state   <= ST_HELD;
                        r_key     <= r_cand;
                        r_key_stb <= 1'b1;
                        r_cnt     <= 4'd0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else if (i_raw == c_key_none) begin
                     r_state <= ST_IDLE;
                     r_cnt   <= 4'd0;
                  end else begin
                     // Different key appeared: restart qualification on it
                     r_cand <= i_raw;
                     r_cnt  <= 4'd1;
                  end
               end
               ST_HELD: begin
                  if (i_raw == r_key) begin
`ifdef KEYPAD_REPEAT_EN
                     // First repeat after REPEAT_DELAY scans, then every REPEAT_PERIOD
                     if (w_rep_inc == c_RD) begin
                        r_key_stb <= 1'b1;
                        r_rep     <= w_rep_inc;
                     end else if (w_rep_inc == c_RDP) begin
                        r_key_stb <= 1'b1;
                        r_rep     <= c_RD;
                     end else begin
                        r_rep <= w_rep_inc;
                     end
`endif
                  end else begin
                     // Anything other than the held key (incl. a second key) starts release
                     r_state <= ST_REL_CHK;
                     r_cnt   <= 4'd1;
`ifdef KEYPAD_REPEAT_EN
                     r_rep   <= 16'd0;
`endif
                  end
               end
               ST_REL_CHK: begin
                  if (i_raw != r_key) begin
                     if (w_cnt_inc == c_DEB) begin
                        r_state <= ST_IDLE;
                        r_key   <= c_key_none;
                        r_cnt   <= 4'd0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_state <= ST_HELD;
                     r_cnt   <= 4'd0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= 4'd0;
               end
            endcase
         end
      end
   end

   assign o_key     = r_key;
   assign o_key_stb = r_key_stb;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module  : keypad_scan
//  Brief   : 4x4 active-low matrix keypad scanner: column drive, row
//            synchronizer, per-scan raw key decode, multi-key flag, and the
//            debounce FSM. Define KEYPAD_REPEAT_EN to enable auto-repeat.
//  Revision: 1.0 - initial release
// ============================================================================
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int SCAN_DIV       = 100_000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 32,
   parameter int REPEAT_PERIOD  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key,
   output logic       key_stb,
   output logic       key_multi
);

   localparam int                c_DIV_W    = $clog2(SCAN_DIV);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);

   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("keypad_scan: SCAN_DIV must be >= 4");
   end

   logic [c_DIV_W-1:0] r_div;
   logic [1:0]         r_col;
   logic [3:0]         r_col_out;
   logic [3:0]         r_row_s1;
   logic [3:0]         r_row_s2;
   logic [1:0]         r_acc_n;     // keys seen so far this scan, saturates at 2
   logic [3:0]         r_acc_code;  // code of the first key seen this scan
   logic               r_key_multi;

   logic               w_slot_end;
   logic               w_scan_end;
   logic [3:0]         w_row_hit;
   logic [2:0]         w_hits_col;
   logic [3:0]         w_code_col;
   logic [2:0]         w_sum;
   logic [3:0]         w_raw;

   assign w_slot_end = (r_div == c_DIV_LAST);
   assign w_scan_end = w_slot_end && (r_col == 2'd3);

   // Two-flop synchronizer for the asynchronous row inputs (idle = pulled up)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_s1 <= 4'hF;
         r_row_s2 <= 4'hF;
      end else begin
         r_row_s1 <= row_in;
         r_row_s2 <= r_row_s1;
      end
   end

   // Slot timer and one-hot active-low column drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div     <= '0;
         r_col     <= 2'd0;
         r_col_out <= 4'b1110;
      end else if (w_slot_end) begin
         r_div     <= '0;
         r_col     <= r_col + 2'd1;
         r_col_out <= ~(4'b0001 << (r_col + 2'd1));
      end else begin
         r_div <= r_div + c_DIV_W'(1);
      end
   end

   // Decode the active column: r3c3 is unpopulated and therefore ignored
   always_comb begin
      w_row_hit  = ~r_row_s2 & ((r_col == 2'd3) ? 4'b0111 : 4'b1111);
      w_hits_col = 3'd0;
      w_code_col = c_key_none;
      for (int r = 3; r >= 0; r--) begin
         if (w_row_hit[r]) begin
            w_hits_col = w_hits_col + 3'd1;
            w_code_col = f_keymap(2'(r), r_col);
         end
      end
      w_sum = {1'b0, r_acc_n} + w_hits_col;
      if (w_sum == 3'd1) begin
         w_raw = (r_acc_n == 2'd1) ? r_acc_code : w_code_col;
      end else begin
         w_raw = c_key_none;
      end
   end

   // Accumulate hits across the four slots; publish the multi-key flag per scan
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_n     <= 2'd0;
         r_acc_code  <= c_key_none;
         r_key_multi <= 1'b0;
      end else if (w_slot_end) begin
         if (w_scan_end) begin
            r_acc_n     <= 2'd0;
            r_acc_code  <= c_key_none;
            r_key_multi <= (w_sum > 3'd1);
         end else begin
            r_acc_n <= (w_sum > 3'd2) ? 2'd2 : w_sum[1:0];
            if (r_acc_n == 2'd0 && w_hits_col != 3'd0) begin
               r_acc_code <= w_code_col;
            end
         end
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .i_scan_end (w_scan_end),
      .i_raw      (w_raw),
      .o_key      (key),
      .o_key_stb  (key_stb)
   );

   assign col_out   = r_col_out;
   assign key_multi = r_key_multi;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module  : tb_keypad_scan
//  Brief   : Directed bench for keypad_scan with a strobe scoreboard. A keypad
//            model drives row_in from col_out and a pressed-key matrix.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

   localparam int SCAN_DIV       = 4;
   localparam int DEBOUNCE_SCANS = 3;
   localparam int REPEAT_DELAY   = 4;
   localparam int REPEAT_PERIOD  = 2;
   localparam int SCAN_CLKS      = 4 * SCAN_DIV;

   logic       clk;
   logic       rst;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key;
   logic       key_stb;
   logic       key_multi;

   // pressed[r] is a column mask of keys held down in row r
   logic [3:0] pressed [4];

   logic [3:0] exp_q [$];
   int         n_checks;
   int         n_fail;

   keypad_scan #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .col_out   (col_out),
      .key       (key),
      .key_stb   (key_stb),
      .key_multi (key_multi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Keypad matrix: a row reads low when a held key sits in a driven-low column
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row_in[r] = ~|(pressed[r] & ~col_out);
      end
   end

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic scans(input int n);
      repeat (n * SCAN_CLKS) @(negedge clk);
   endtask

   task automatic clear_keys();
      for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
   endtask

   // Expected strobes for a key held from a scan boundary for hold scans, from IDLE
   task automatic push_hold(input logic [3:0] code, input int hold);
      exp_q.push_back(code);
`ifdef KEYPAD_REPEAT_EN
      for (int s = DEBOUNCE_SCANS + REPEAT_DELAY; s <= hold; s += REPEAT_PERIOD) begin
         exp_q.push_back(code);
      end
`endif
   endtask

   // Scoreboard monitor: every strobe must match the next expected code
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (key_stb === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL strobe_unexpected: got key %h with no strobe expected", key);
            end else begin
               e = exp_q.pop_front();
               if (key !== e) begin
                  n_fail++;
                  $display("FAIL strobe_key: got %h expected %h", key, e);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_col;
      n_checks = 0;
      n_fail   = 0;
      clear_keys();
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check4("reset_col_out", col_out, 4'b1110);
      check4("reset_key", key, 4'hF);
      check1("reset_key_stb", key_stb, 1'b0);
      check1("reset_key_multi", key_multi, 1'b0);
      rst = 1'b0;

      // 1: idle scanning, column walks every SCAN_DIV clocks
      for (int k = 0; k < SCAN_CLKS; k++) begin
         exp_col = ~(4'b0001 << (k / SCAN_DIV));
         check4("idle_col_out", col_out, exp_col);
         @(negedge clk);
      end
      check4("idle_key", key, 4'hF);

      // 2: hold "2" (r0c1) for 10 scans, then release
      push_hold(4'h2, 10);
      pressed[0][1] = 1'b1;
      scans(2);
      check4("t2_key_before_accept", key, 4'hF);
      scans(2);
      check4("t2_key_accepted", key, 4'h2);
      scans(6);
      clear_keys();
      scans(2);
      check4("t2_key_during_release", key, 4'h2);
      scans(2);
      check4("t2_key_released", key, 4'hF);

      // 3: esc (r3c0) bouncing one scan on / one off, then stable
      for (int i = 0; i < 3; i++) begin
         pressed[3][0] = 1'b1;
         scans(1);
         pressed[3][0] = 1'b0;
         scans(1);
      end
      check4("t3_key_bounce", key, 4'hF);
      push_hold(4'hE, 4);
      pressed[3][0] = 1'b1;
      scans(4);
      check4("t3_key_esc", key, 4'hE);
      clear_keys();
      scans(4);
      check4("t3_key_released", key, 4'hF);

      // 4: "2" and "4" together, then drop "4"
      pressed[0][1] = 1'b1;
      pressed[1][0] = 1'b1;
      scans(2);
      check1("t4_multi_set", key_multi, 1'b1);
      check4("t4_key_multi_none", key, 4'hF);
      push_hold(4'h2, 4);
      pressed[1][0] = 1'b0;
      scans(4);
      check4("t4_key_2", key, 4'h2);
      check1("t4_multi_clear", key_multi, 1'b0);
      clear_keys();
      scans(4);
      check4("t4_key_released", key, 4'hF);

      // 5: hold "3", add "4", release "3"
      push_hold(4'h3, 4);
      pressed[0][2] = 1'b1;
      scans(4);
      check4("t5_key_3", key, 4'h3);
      pressed[1][0] = 1'b1;
      scans(4);
      check4("t5_key_released_by_second", key, 4'hF);
      check1("t5_multi", key_multi, 1'b1);
      push_hold(4'h4, 4);
      pressed[0][2] = 1'b0;
      scans(4);
      check4("t5_key_4", key, 4'h4);
      clear_keys();
      scans(4);
      check4("t5_key_released", key, 4'hF);

      // 5b: reset asserted while "7" is in press qualification
      pressed[2][0] = 1'b1;
      scans(2);
      #2 rst = 1'b1;
      #1;
      check4("t5_rst_key", key, 4'hF);
      check1("t5_rst_stb", key_stb, 1'b0);
      check4("t5_rst_col_out", col_out, 4'b1110);
      check1("t5_rst_multi", key_multi, 1'b0);
      clear_keys();
      @(negedge clk);
      rst = 1'b0;
      scans(5);
      check4("t5_after_rst_key", key, 4'hF);

      // 6: hold "5" for 14 scans (repeat strobes only with KEYPAD_REPEAT_EN)
      push_hold(4'h5, 14);
      pressed[1][1] = 1'b1;
      scans(14);
      check4("t6_key_5", key, 4'h5);
      clear_keys();
      scans(4);
      check4("t6_key_released", key, 4'hF);

      scans(1);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL strobe_missing: got %0d strobes outstanding expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
